// File: rtl/icache_refill_responder_pkg.sv
// Shared configuration, state encoding and size helpers for the icache refill responder.
package icache_refill_responder_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned ICACHE_LINE_WIDTH;
    } user_cfg_t;

    localparam user_cfg_t DefaultCfg = '{XLEN: 32, ICACHE_LINE_WIDTH: 32};

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDrain
    } refill_state_e;

    function automatic int unsigned line_bits(input user_cfg_t cfg);
        return cfg.ICACHE_LINE_WIDTH * 8;
    endfunction

    function automatic int unsigned refill_beats(input user_cfg_t cfg);
        return line_bits(cfg) / cfg.XLEN;
    endfunction

endpackage

// File: rtl/icache_refill_responder.sv
// Refills one icache line by reading XLEN-bit beats from memory, one outstanding read at a time,
// and returns the assembled line. flush_i abandons the refill, draining any read still in flight.
module icache_refill_responder
    import icache_refill_responder_pkg::*;
#(
    parameter user_cfg_t   Cfg       = DefaultCfg,
    parameter int unsigned LINE_BITS = line_bits(Cfg),
    parameter int unsigned BEATS     = refill_beats(Cfg)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [Cfg.XLEN-1:0]   req_addr_i,
    input  logic                  flush_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [LINE_BITS-1:0]  rsp_line_o,
    output logic [Cfg.XLEN-1:0]   rsp_addr_o,
    output logic                  rsp_err_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [Cfg.XLEN-1:0]   mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [Cfg.XLEN-1:0]   mem_rsp_data_i,
    input  logic                  mem_rsp_err_i
);

    localparam int unsigned XLEN   = Cfg.XLEN;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned OFF_W  = $clog2(Cfg.ICACHE_LINE_WIDTH);
    localparam int unsigned BYTE_W = $clog2(XLEN / 8);

    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : gen_bad_beats
        $error("BEATS must be a power of two >= 2");
    end

    refill_state_e         state_q, state_d;
    logic [XLEN-1:0]       base_q, base_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [LINE_BITS-1:0]  line_q, line_d;
    logic                  err_q, err_d;

    // Offset bits within the line are dropped when the base is latched.
    logic unused_offset;
    assign unused_offset = ^req_addr_i[OFF_W-1:0];

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        beat_d          = beat_q;
        line_d          = line_q;
        err_d           = err_q;
        req_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        rsp_valid_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = !flush_i;
                if (!flush_i && req_valid_i) begin
                    base_d  = {req_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_req_valid_o = 1'b1;
                // A read accepted in the flush cycle is still in flight and must be drained.
                if (flush_i) begin
                    state_d = mem_req_ready_i ? StDrain : StIdle;
                end else if (mem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_rsp_valid_i) begin
                    if (flush_i) begin
                        state_d = StIdle;
                    end else begin
                        line_d[beat_q*XLEN +: XLEN] = mem_rsp_data_i;
                        err_d = err_q | mem_rsp_err_i;
                        if (beat_q == BEAT_W'(BEATS - 1)) begin
                            state_d = StResp;
                        end else begin
                            beat_d  = beat_q + BEAT_W'(1);
                            state_d = StIssue;
                        end
                    end
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                rsp_valid_o = !flush_i;
                if (flush_i || rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (mem_rsp_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            base_q  <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

    assign mem_req_addr_o = base_q + (XLEN'(beat_q) << BYTE_W);
    assign rsp_line_o     = line_q;
    assign rsp_addr_o     = base_q;
    assign rsp_err_o      = err_q;

    mem_rsp_only_when_waiting_a: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rsp_valid_i |-> (state_q == StWait || state_q == StDrain));

endmodule

// File: tb/tb_icache_refill_responder.sv
// Randomized scoreboard bench for icache_refill_responder with a behavioural memory model.
module tb_icache_refill_responder;
    import icache_refill_responder_pkg::*;

    typedef struct {
        logic [255:0] line;
        logic [31:0]  addr;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         req_valid_i, req_ready_o, flush_i;
    logic [31:0]  req_addr_i;
    logic         rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [255:0] rsp_line_o;
    logic [31:0]  rsp_addr_o;
    logic         mem_req_valid_o, mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic         mem_rsp_valid_i, mem_rsp_err_i;
    logic [31:0]  mem_rsp_data_i;

    exp_t        exp_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          mem_lat = 1, mem_stall = 0, rsp_stall = 0, err_beat = 8, data_mode = 0;
    logic [31:0] seed = 32'h0;
    logic [31:0] cur_base = 32'h0;
    int          hs_cnt = 0, rsp_cnt = 0;
    bit          pending = 1'b0;

    always #5 clk = ~clk;

    icache_refill_responder dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .flush_i         (flush_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_line_o      (rsp_line_o),
        .rsp_addr_o      (rsp_addr_o),
        .rsp_err_o       (rsp_err_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_err_i   (mem_rsp_err_i)
    );

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        if (data_mode == 0) return (a >> 2) & 32'h7;
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endfunction

    // Memory: one read at a time, fixed latency, data derived from the address.
    initial begin : mem_model
        int          wait_cnt, lat_cnt;
        bit          stalled;
        logic [31:0] held_addr, pend_data;
        logic        pend_err;
        wait_cnt = 0; lat_cnt = 0; stalled = 0; held_addr = '0; pend_data = '0; pend_err = 0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = '0; mem_rsp_err_i = 0;
        forever begin
            @(negedge clk);
            mem_rsp_valid_i = 0;
            if (rst_i) begin
                pending = 0;
            end else if (pending) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mem_rsp_valid_i = 1;
                    mem_rsp_data_i  = pend_data;
                    mem_rsp_err_i   = pend_err;
                    pending         = 0;
                end
            end
            mem_req_ready_i = (wait_cnt >= mem_stall);
            #2;
            if (mem_req_valid_o) begin
                if (stalled) chk("mem_addr_stable", mem_req_addr_o, held_addr);
                if (mem_req_ready_i) begin
                    chk("mem_addr", mem_req_addr_o, cur_base + 32'(hs_cnt * 4));
                    chk("single_outstanding", {pending, mem_rsp_valid_i}, 0);
                    pend_data = data_fn(mem_req_addr_o);
                    pend_err  = (hs_cnt == err_beat);
                    pending   = 1;
                    lat_cnt   = mem_lat;
                    hs_cnt++;
                    wait_cnt  = 0;
                    stalled   = 0;
                end else begin
                    wait_cnt++;
                    stalled   = 1;
                    held_addr = mem_req_addr_o;
                end
            end else begin
                wait_cnt = 0;
                stalled  = 0;
            end
        end
    end

    // Response monitor: drives rsp_ready_i backpressure and pops the scoreboard on handshake.
    initial begin : rsp_monitor
        int           rsp_wait;
        bit           rsp_stalled;
        logic [255:0] h_line;
        logic [31:0]  h_addr;
        logic         h_err;
        exp_t         e;
        rsp_wait = 0; rsp_stalled = 0; h_line = '0; h_addr = '0; h_err = 0;
        rsp_ready_i = 0;
        forever begin
            @(negedge clk);
            rsp_ready_i = (rsp_wait >= rsp_stall);
            #2;
            if (rsp_valid_o) begin
                if (rsp_stalled) begin
                    chk("rsp_line_stable", rsp_line_o, h_line);
                    chk("rsp_addr_stable", rsp_addr_o, h_addr);
                    chk("rsp_err_stable", rsp_err_o, h_err);
                end
                if (rsp_ready_i) begin
                    rsp_cnt++;
                    rsp_wait    = 0;
                    rsp_stalled = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_rsp: got addr %0h want no response", rsp_addr_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_line", rsp_line_o, e.line);
                        chk("rsp_addr", rsp_addr_o, e.addr);
                        chk("rsp_err", rsp_err_o, e.err);
                    end
                end else begin
                    rsp_wait++;
                    rsp_stalled = 1;
                    h_line = rsp_line_o;
                    h_addr = rsp_addr_o;
                    h_err  = rsp_err_o;
                end
            end else begin
                rsp_wait    = 0;
                rsp_stalled = 0;
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input bit want_rsp);
        bit          acc;
        exp_t        e;
        logic [31:0] base;
        acc = 0;
        @(negedge clk);
        req_valid_i = 1;
        req_addr_i  = addr;
        for (int i = 0; i < 100 && !acc; i++) begin
            #3;
            if (req_ready_o) begin
                acc      = 1;
                base     = addr & 32'hFFFF_FFE0;
                cur_base = base;
                hs_cnt   = 0;
                if (want_rsp) begin
                    e.line = '0;
                    e.err  = 0;
                    e.addr = base;
                    for (int k = 0; k < 8; k++) begin
                        e.line[k*32 +: 32] = data_fn(base + 32'(k * 4));
                        if (k == err_beat) e.err = 1;
                    end
                    exp_q.push_back(e);
                end
            end
            @(negedge clk);
        end
        req_valid_i = 0;
        chk("req_accept", acc, 1);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && req_ready_o && !pending && !mem_rsp_valid_i) done = 1;
        end
        chk({name, "_done"}, done, 1);
    endtask

    // what: 0 hs_cnt>=n, 1 mem request, 2 mem response, 3 stalled mem request
    task automatic poll(input int what, input int n, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            #3;
            case (what)
                0:       hit = (hs_cnt >= n);
                1:       hit = mem_req_valid_o;
                2:       hit = mem_rsp_valid_i;
                default: hit = mem_req_valid_o && !mem_req_ready_i;
            endcase
        end
        chk(name, hit, 1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req_ready"}, req_ready_o, 1);
        chk({name, "_rsp_valid"}, rsp_valid_o, 0);
        chk({name, "_mem_valid"}, mem_req_valid_o, 0);
        chk({name, "_line"}, rsp_line_o, 0);
        chk({name, "_addr"}, rsp_addr_o, 0);
        chk({name, "_err"}, rsp_err_o, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int r0;
        rst_i = 1; req_valid_i = 0; req_addr_i = '0; flush_i = 0;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_i = 0;

        // Basic refill, data equals beat index.
        do_req(32'h8000_0014, 1);
        wait_idle("basic");
        chk("basic_reads", hs_cnt, 8);

        // Backpressure on both sides.
        mem_stall = 3; rsp_stall = 5; data_mode = 1; seed = 32'h1234_5678;
        r0 = rsp_cnt;
        do_req(32'h0000_4468, 1);
        wait_idle("bp");
        chk("bp_reads", hs_cnt, 8);
        chk("bp_single_rsp", rsp_cnt - r0, 1);

        // Error on beat 5 only.
        mem_stall = 0; rsp_stall = 0; mem_lat = 2; err_beat = 5;
        do_req(32'h1000_0020, 1);
        wait_idle("errbeat");
        chk("err_reads", hs_cnt, 8);
        err_beat = 8;

        // Flush in WAIT at beat 3, response due four cycles later.
        mem_lat = 5;
        r0 = rsp_cnt;
        do_req(32'h0000_0200, 0);
        poll(0, 4, "flush_wait_reach");
        @(negedge clk); flush_i = 1;
        @(negedge clk); flush_i = 0;
        for (int i = 0; i < 50; i++) begin
            #3;
            if (!(pending || mem_rsp_valid_i)) break;
            chk("drain_not_ready", req_ready_o, 0);
            chk("drain_no_mem_req", mem_req_valid_o, 0);
            @(negedge clk);
        end
        chk("drain_done_ready", req_ready_o, 1);
        chk("flush_no_rsp", rsp_cnt - r0, 0);
        mem_lat = 1;
        do_req(32'h0000_0100, 1);
        wait_idle("after_flush");

        // Flush together with the memory handshake.
        mem_lat = 3;
        do_req(32'h0000_3000, 0);
        poll(0, 1, "flush_hs_reach");
        poll(1, 0, "flush_hs_issue");
        flush_i = 1;
        @(negedge clk); flush_i = 0;
        #3;
        chk("flush_hs_drain_ready", req_ready_o, 0);
        chk("flush_hs_drain_mem", mem_req_valid_o, 0);
        wait_idle("flush_hs");
        chk("flush_hs_reads", hs_cnt, 2);

        // Flush together with a memory response.
        mem_lat = 2;
        do_req(32'h0000_5040, 0);
        poll(0, 3, "flush_rsp_reach");
        poll(2, 0, "flush_rsp_resp");
        flush_i = 1;
        @(negedge clk); flush_i = 0;
        #3;
        chk("flush_rsp_idle", req_ready_o, 1);
        chk("flush_rsp_no_mem", mem_req_valid_o, 0);
        chk("flush_rsp_reads", hs_cnt, 3);

        // Flush in ISSUE while memory is stalling.
        mem_stall = 3;
        do_req(32'h0000_6000, 0);
        poll(3, 0, "flush_issue_reach");
        flush_i = 1;
        @(negedge clk); flush_i = 0;
        #3;
        chk("flush_issue_idle", req_ready_o, 1);
        chk("flush_issue_nothing_out", {pending, 24'(hs_cnt)}, 0);
        mem_stall = 0;
        chk("flush_total_rsps", rsp_cnt - r0, 1);

        // Asynchronous reset in the middle of WAIT.
        mem_lat = 8;
        do_req(32'h0000_7000, 0);
        poll(0, 3, "reset_reach");
        @(negedge clk);
        #3;
        rst_i = 1;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk); rst_i = 0;
        mem_lat = 1;
        do_req(32'h0000_8010, 1);
        wait_idle("after_reset");

        // Randomized refills.
        for (int t = 0; t < 10; t++) begin
            mem_lat   = $urandom_range(1, 4);
            mem_stall = $urandom_range(0, 2);
            rsp_stall = $urandom_range(0, 2);
            err_beat  = $urandom_range(0, 11);
            seed      = $urandom;
            do_req($urandom, 1);
            wait_idle("rand");
            chk("rand_reads", hs_cnt, 8);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_refill_responder.md
Name: icache_refill_responder

Overview:
- Memory-side responder for instruction-cache miss refills.
- Accepts one line-fill request from the icache miss handler.
- Reads the line from the backing memory as consecutive XLEN-bit beats, one outstanding read at a time.
- Assembles the beats and returns the whole line to the icache. Sits between the icache miss path and the memory/bus adapter.

Parameters:
- Cfg, config_pkg::user_cfg_t default, supplies XLEN (32) and ICACHE_LINE_WIDTH (bytes per line, 32).
- LINE_BITS, Cfg.ICACHE_LINE_WIDTH*8 (256), derived line width in bits.
- BEATS, LINE_BITS/Cfg.XLEN (8), derived beats per line; must be a power of two ≥2 (elaboration assertion).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  refill request valid
- req_ready_o  out  1  responder can accept request
- req_addr_i  in  XLEN  miss address (any byte within line)
- flush_i  in  1  abandon current refill
- rsp_valid_o  out  1  line response valid
- rsp_ready_i  in  1  icache accepts line
- rsp_line_o  out  LINE_BITS  assembled line, beat 0 in LSBs
- rsp_addr_o  out  XLEN  line-aligned address of returned line
- rsp_err_o  out  1  any beat returned error
- mem_req_valid_o  out  1  beat read request
- mem_req_ready_i  in  1  memory accepts read
- mem_req_addr_o  out  XLEN  beat address (XLEN/8-aligned)
- mem_rsp_valid_i  in  1  read data valid (arbitrary latency ≥1)
- mem_rsp_data_i  in  XLEN  read data
- mem_rsp_err_i  in  1  read error, qualified by mem_rsp_valid_i

Behaviour:
- Reset (async, rst_i=1): state=IDLE; req_ready_o=1; rsp_valid_o=0; mem_req_valid_o=0; rsp_line_o, rsp_addr_o, rsp_err_o, beat counter =0.
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: req_ready_o=1. On req_valid_i, latch base=req_addr_i with low log2(ICACHE_LINE_WIDTH) bits cleared; beat=0; err=0; go ISSUE.
- ISSUE: mem_req_valid_o=1; mem_req_addr_o=base+beat*(XLEN/8). Hold valid and address stable until mem_req_ready_i; on handshake go WAIT.
- WAIT: on mem_rsp_valid_i, write data into slice [beat*XLEN +: XLEN]; err |= mem_rsp_err_i. If beat==BEATS-1 go RESP, else beat++ and go ISSUE. The first re-issue is one cycle after the response.
- Timing: minimum latency from request accept to rsp_valid_o is BEATS*(1+memory latency)+1 cycles.
- Beat counter is log2(BEATS) bits wide and wraps only via reset to 0 on a new request.
- RESP: rsp_valid_o=1 with line/addr/err stable until rsp_ready_i; on handshake go IDLE. A new request can be accepted in the next cycle, not the same one.
- Errors do not abort the refill; all BEATS beats are still read.
- mem_rsp_valid_i in IDLE/ISSUE/RESP is a protocol violation and is ignored (assertion).
- flush_i has priority over every other event in the same cycle:
  - IDLE: no effect; a req_valid_i that cycle is not accepted.
  - ISSUE without handshake: go IDLE, no memory request left outstanding.
  - ISSUE with mem handshake that cycle: go DRAIN.
  - WAIT with mem_rsp_valid_i that cycle: response consumed, go IDLE.
  - WAIT without mem_rsp_valid_i: go DRAIN.
  - RESP: drop rsp_valid_o, go IDLE.
- DRAIN: req_ready_o=0, mem_req_valid_o=0; wait for mem_rsp_valid_i, discard the data, go IDLE. flush_i in DRAIN has no extra effect.
- rsp_valid_o never asserts for a flushed refill.

Decomposition:
- config_pkg gains refill_state_e (5-state enum) and helper functions line_bits(Cfg) and refill_beats(Cfg).
- No sub-module needed; the line assembly register is inline.
- An optional shared assertion bind file checks: valid/address stability under backpressure, single outstanding read, and flush never leaving a request outstanding.

Test Plan:
- Basic refill: req_addr 0x8000_0014, memory latency 1, data = beat index → 8 mem reads at 0x8000_0000..0x8000_001C; rsp_addr 0x8000_0000; rsp_line word k = k; rsp_err 0.
- Backpressure: mem_req_ready_i low 3 cycles per beat and rsp_ready_i low 5 cycles → addresses held stable; line stable; exactly 8 reads; a single response.
- Error beat: mem_rsp_err_i=1 on beat 5 only → all 8 beats read; rsp_err_o=1; other words correct.
- Flush in WAIT at beat 3 with response due 4 cycles later → DRAIN; req_ready_o=0 until the response arrives; no rsp_valid_o. A following request at 0x100 returns a correct line.
- Flush coinciding with the mem handshake, and flush coinciding with mem_rsp_valid_i → go DRAIN and IDLE respectively; no stray outstanding read.
- Async reset asserted mid-WAIT → outputs at reset values immediately; the next refill completes normally.
